// File: rtl/pipe_pkg.sv
// Shared pipeline types: widths, register index constants, operand forwarding
// select encoding and the ID/EX pipeline register layout.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] R0 = '0;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] ridx_t;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_t;

  typedef struct packed {
    logic  valid;
    logic  we;
    logic  load;
    word_t pc;
    word_t a;
    word_t b;
    word_t imm;
    ridx_t rw;
  } idex_t;

  function automatic word_t fwd_pick(input fwd_sel_t sel, input word_t ex_result,
                                     input word_t mem_data, input word_t wb_data,
                                     input word_t rf_q);
    word_t v;
    case (sel)
      FWD_EX:  v = ex_result;
      FWD_MEM: v = mem_data;
      FWD_WB:  v = wb_data;
      FWD_RF:  v = rf_q;
      default: v = '0;
    endcase
    return v;
  endfunction

  // True when the operand bypassed the register file (zero source does not count).
  function automatic logic is_bypass(input fwd_sel_t sel);
    return (sel == FWD_EX) || (sel == FWD_MEM) || (sel == FWD_WB);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Forwarding source select for one source operand; purely combinational.
// Youngest producer wins; EX loads are excluded since their data is not ready yet.
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rw,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rw,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rw,
  output fwd_sel_t          sel
);

  always_comb begin
    sel = FWD_RF;
    if (src == R0) begin
      sel = FWD_ZERO;
    end else if (ex_valid && ex_we && !ex_load && (ex_rw == src)) begin
      sel = FWD_EX;
    end else if (mem_we && (mem_rw == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rw == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX operand stage: forwarding, load-use stall, 1-cycle ID/EX register; EX never backpressures.
// ID_EX_HAZARD_STATS_EN adds stall_cnt/fwd_cnt counters and a per-capture trace.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_we,
  input  logic              id_load,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   rf_qa,
  input  logic [XLEN-1:0]   rf_qb,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [REG_AW-1:0] mem_rw,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [REG_AW-1:0] wb_rw,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_we,
  output logic              ex_load,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rw
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  idex_t    ex_q;
  idex_t    ex_d;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;
  word_t    opa;
  word_t    opb;
  logic     hz;
  logic     capture;

  fwd_mux u_fwd_a (
    .src      (id_ra),
    .ex_valid (ex_q.valid),
    .ex_we    (ex_q.we),
    .ex_load  (ex_q.load),
    .ex_rw    (ex_q.rw),
    .mem_we   (mem_we),
    .mem_rw   (mem_rw),
    .wb_we    (wb_we),
    .wb_rw    (wb_rw),
    .sel      (sel_a)
  );

  fwd_mux u_fwd_b (
    .src      (id_rb),
    .ex_valid (ex_q.valid),
    .ex_we    (ex_q.we),
    .ex_load  (ex_q.load),
    .ex_rw    (ex_q.rw),
    .mem_we   (mem_we),
    .mem_rw   (mem_rw),
    .wb_we    (wb_we),
    .wb_rw    (wb_rw),
    .sel      (sel_b)
  );

  assign opa = fwd_pick(sel_a, ex_result, mem_data, wb_data, rf_qa);
  assign opb = fwd_pick(sel_b, ex_result, mem_data, wb_data, rf_qb);

  // A load in EX has no data until MEM, so a dependent ID instruction waits one cycle.
  assign hz = id_valid & ex_q.valid & ex_q.load & ex_q.we & (ex_q.rw != R0)
            & ((ex_q.rw == id_ra) | (ex_q.rw == id_rb));

  assign stall   = hz & ~flush;
  assign capture = ~(flush | hz);

  always_comb begin
    ex_d = '0;
    if (capture) begin
      ex_d.valid = id_valid;
      ex_d.we    = id_we & id_valid & (id_rw != R0);
      ex_d.load  = id_load & id_valid;
      ex_d.pc    = id_pc;
      ex_d.a     = opa;
      ex_d.b     = opb;
      ex_d.imm   = id_imm;
      ex_d.rw    = id_rw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid = ex_q.valid;
  assign ex_we    = ex_q.we;
  assign ex_load  = ex_q.load;
  assign ex_pc    = ex_q.pc;
  assign ex_a     = ex_q.a;
  assign ex_b     = ex_q.b;
  assign ex_imm   = ex_q.imm;
  assign ex_rw    = ex_q.rw;

`ifdef ID_EX_HAZARD_STATS_EN
  logic fwd_hit;

  assign fwd_hit = capture & id_valid & (is_bypass(sel_a) | is_bypass(sel_b));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(stall);
      fwd_cnt   <= fwd_cnt + 32'(fwd_hit);
      if (capture && id_valid) begin
        $display("%0t@%h: a=%s/%h b=%s/%h", $time, id_pc, sel_a.name(), opa,
                 sel_b.name(), opb);
      end
    end
  end
`endif

endmodule
